// File: rtl/inv_key_expansion_if.sv
// Handshake bundle between a reverse key-schedule requester/consumer and the
// inverse AES-128 key expansion engine.
interface inv_key_expansion_if;
  logic           start;
  logic [0:127]   last_key;
  logic           key_ready;
  logic           key_valid;
  logic [0:127]   round_key;
  logic [3:0]     round_out;
  logic           busy;
  logic           done;

  modport master (
    output start, last_key, key_ready,
    input  key_valid, round_key, round_out, busy, done
  );

  modport slave (
    input  start, last_key, key_ready,
    output key_valid, round_key, round_out, busy, done
  );
endinterface

// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: walks from the round-10 key back to the cipher
// key, one round key per accepted beat, using four parallel forward S-boxes.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Row-major forward S-box; entry i lives at bits [8*i +: 8].
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TBL[{a, 3'b000} +: 8];
endmodule

module inv_key_expansion (
  input  logic                 clk,
  input  logic                 rst,
  inv_key_expansion_if.slave   kif
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [0:127]   round_key_q, round_key_d;
  logic [3:0]     round_q, round_d;
  logic           key_valid_q, key_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    p0, p1, p2, p3;
  logic [31:0]    rot, sub;
  logic [7:0]     rcon;
  logic [0:127]   inv_key;
  logic           beat;

  assign w0 = round_key_q[0:31];
  assign w1 = round_key_q[32:63];
  assign w2 = round_key_q[64:95];
  assign w3 = round_key_q[96:127];

  // Undo the forward XOR chain first, then recover w0 via the usual g() term.
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
  end

  always_comb begin
    rcon = 8'h00;
    unique case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p0      = w0 ^ sub ^ {rcon, 24'h000000};
  assign inv_key = {p0, p1, p2, p3};
  assign beat    = key_valid_q & kif.key_ready;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_d     = round_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (kif.start) begin
          state_d     = RUN;
          round_key_d = kif.last_key;
          round_d     = 4'd10;
          key_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      RUN: begin
        // start is deliberately not looked at here; a running schedule is never disturbed.
        if (beat) begin
          if (round_q != 4'd0) begin
            round_key_d = inv_key;
            round_d     = round_q - 4'd1;
          end else begin
            state_d     = IDLE;
            key_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_q     <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_q     <= round_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign kif.key_valid = key_valid_q;
  assign kif.round_key = round_key_q;
  assign kif.round_out = round_q;
  assign kif.busy      = busy_q;
  assign kif.done      = done_q;
endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench: expected round keys come from a forward AES-128 key
// expansion (S-box derived from GF(2^8) inverse + affine map) run from round 0.
module tb_inv_key_expansion;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_key_expansion_if kif();
  inv_key_expansion dut (.clk(clk), .rst(rst), .kif(kif));

  typedef struct { logic [3:0] rnd; logic [0:127] key; } exp_t;
  exp_t         sb[$];
  exp_t         e;
  int           n_tests = 0, n_fail = 0, cyc = 0, start_cyc = 0;
  logic [7:0]   sbox_t[256];
  logic [7:0]   rcon_t[11];
  logic [0:127] exp_rk[11];
  bit           rdy_rand = 1'b0, lat_chk = 1'b0, done_due = 1'b0, post_rst = 1'b0;
  bit           held = 1'b0, just_started = 1'b0, was_idle;
  logic [0:127] snap_key;
  logic [3:0]   snap_rnd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] r = {w[23:0], w[31:24]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  // Forward schedule from the cipher key; exp_rk[r] is round key r.
  task automatic expand(input logic [0:127] k0);
    logic [31:0] w[44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subrot(t) ^ {rcon_t[i/4], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Caller is positioned just after a rising edge; start is held for one cycle.
  task automatic drive_start(input logic [0:127] k0);
    expand(k0);
    kif.start    = 1'b1;
    kif.last_key = exp_rk[10];
    @(posedge clk); #1;
    kif.start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (kif.done) return;
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (kif.key_valid && kif.round_out == r) return;
    end
    chk("wait_round_timeout", 0, 1);
  endtask

  function automatic logic [0:127] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    kif.key_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (post_rst) begin
      chk("rst_round_key", kif.round_key, 0);
      chk("rst_round_out", kif.round_out, 0);
      post_rst = 1'b0;
    end
    chk("key_valid", kif.key_valid, sb.size() != 0);
    chk("busy", kif.busy, sb.size() != 0);
    chk("done", kif.done, done_due);
    done_due = 1'b0;
    if (held) begin
      chk("hold_key", kif.round_key, snap_key);
      chk("hold_round", kif.round_out, snap_rnd);
      held = 1'b0;
    end
    if (just_started && sb.size() != 0) begin
      chk("first_round", kif.round_out, 4'd10);
      chk("first_key", kif.round_key, sb[0].key);
    end
    just_started = 1'b0;
    if (rst) begin
      sb.delete();
      post_rst = 1'b1;
    end else begin
      was_idle = (sb.size() == 0);
      if (kif.key_valid && kif.key_ready) begin
        if (sb.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("beat_round", kif.round_out, e.rnd);
          chk("beat_key", kif.round_key, e.key);
          if (e.rnd == 4'd0) begin
            done_due = 1'b1;
            if (lat_chk) chk("done_latency", cyc + 1 - start_cyc, 12);
          end
        end
      end else if (kif.key_valid) begin
        held     = 1'b1;
        snap_key = kif.round_key;
        snap_rnd = kif.round_out;
      end
      if (kif.start && was_idle) begin
        for (int r = 10; r >= 0; r--) sb.push_back('{rnd: 4'(r), key: exp_rk[r]});
        start_cyc    = cyc;
        lat_chk      = !rdy_rand;
        just_started = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] inv, s, rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
    rc = 8'h01;
    rcon_t[0] = 8'h00;
    for (int i = 1; i < 11; i++) begin
      rcon_t[i] = rc;
      rc = gmul(rc, 8'h02);
    end

    rst = 1'b1; kif.start = 1'b0; kif.last_key = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All-zero cipher key: last round b4ef5bcb..., round 1 6263..., round 0 zero.
    @(posedge clk); #1;
    drive_start(128'h0);
    wait_done("zero_key");

    // FIPS-197 example key, ready held high.
    @(posedge clk); #1;
    drive_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_done("fips_key");

    // Same key with back-pressure.
    rdy_rand = 1'b1;
    @(posedge clk); #1;
    drive_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_done("fips_key_bp");
    rdy_rand = 1'b0;

    // start mid-schedule must be ignored.
    @(posedge clk); #1;
    drive_start(rnd_key());
    wait_round(4'd6);
    kif.start = 1'b1; kif.last_key = rnd_key();
    @(posedge clk); #1;
    kif.start = 1'b0;
    wait_done("ignored_start");

    // Reset in the middle of a schedule, then a clean restart.
    @(posedge clk); #1;
    drive_start(rnd_key());
    wait_round(4'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_start(rnd_key());
    wait_done("after_rst");

    // start in the done cycle begins the next schedule immediately.
    drive_start(rnd_key());
    wait_done("back_to_back");

    rdy_rand = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      drive_start(rnd_key());
      wait_done("rand_key");
    end
    rdy_rand = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 start  input  1  request to begin a reverse schedule; sampled on rising clk.
REQ-003 last_key  input  [0:127]  round-10 AES-128 round key; sampled only on start acceptance; bit 0 = MSB of word 0.
REQ-004 key_ready  input  1  consumer accepts the presented round key this cycle.
REQ-005 key_valid  output  1  round_key/round_out hold a valid round key.
REQ-006 round_key  output  [0:127]  current round key; words w0..w3 = bits [0:31],[32:63],[64:95],[96:127].
REQ-007 round_out  output  [3:0]  round number of round_key, 10 down to 0.
REQ-008 busy  output  1  high while a schedule is in progress.
REQ-009 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-010 All outputs SHALL be registered.
REQ-011 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-012 In IDLE with start=1: next cycle state=RUN, round_key=last_key, round_out=10, key_valid=1, busy=1.
REQ-013 A beat SHALL occur when key_valid=1 and key_ready=1 in the same cycle.
REQ-014 RUN, beat, round_out>0: next cycle round_key=INV(round_key, round_out), round_out=round_out-1, key_valid stays 1.
REQ-015 RUN, beat, round_out=0: next cycle state=IDLE, key_valid=0, busy=0, done=1 for exactly one cycle; round_key and round_out hold last values.
REQ-016 RUN, key_valid=1, key_ready=0: round_key, round_out, key_valid SHALL hold unchanged for any number of cycles.
REQ-017 INV(k, r) for input words w0..w3: p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^{Rcon[r],00,00,00}.
REQ-018 RotWord SHALL be a 1-byte left rotate {a,b,c,d}->{b,c,d,a}; SubWord SHALL apply the forward AES S-box to each of its 4 bytes, using four parallel S-box instances.
REQ-019 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex); index is the round_out value of the key being reversed.
REQ-020 Each INV step SHALL complete in one clock; throughput is one round key per cycle with key_ready held high.
REQ-021 Latency: round 10 presented 1 cycle after start; round 0 presented 11 cycles after start with key_ready=1; done 12 cycles after start.
REQ-022 start while state=RUN SHALL be ignored with no effect on state or outputs.
REQ-023 start in the same cycle as done=1 (state IDLE) SHALL be accepted per REQ-012; done still pulses.
REQ-024 Intermediate values SHALL be 8-bit XOR only, with no carries and no width growth.

Reset
REQ-025 rst=1 at a rising clk edge SHALL force state=IDLE, key_valid=0, busy=0, done=0, round_out=0, round_key=0.
REQ-026 rst SHALL take priority over start and key_ready, including mid-schedule.
REQ-027 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-028 last_key=b4ef5bcb3e92e21123e951cf6f8f188e, key_ready=1 -> 11 beats; round 10 = last_key; round 1 = 62636363626363636263636362636363; round 0 = 0; done at cycle 12.
REQ-029 last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
REQ-030 Same stimulus as REQ-029 with key_ready toggling pseudo-randomly -> identical key sequence; outputs stable while key_ready=0; done only after round 0 is accepted.
REQ-031 start pulsed again with a different last_key at round_out=6 -> ignored; sequence continues 5..0 from the original key.
REQ-032 rst=1 at round_out=5 -> next cycle all outputs 0, busy=0; new start is accepted and produces a correct full sequence.
REQ-033 start asserted in the done cycle -> new schedule begins; round 10 presented on the following cycle.
